// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default bus widths,
// FSM state encoding and port identifiers.
package ram_arbiter_pkg;

    // Default shared-RAM geometry
    localparam int unsigned RAM_ADDR_W = 8;
    localparam int unsigned RAM_DATA_W = 16;

    // FSM state encoding (kept as plain constants for legacy compatibility)
    localparam int unsigned STATE_W  = 2;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_RWAIT = 2'd2;

    // Port identifiers as carried in the winner register
    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-input round-robin picker. Holds a one-bit priority pointer naming the
// port that wins a tie; the pointer moves to the other port only when the
// current pick is actually accepted by the owner of this arbiter.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_valid,
    output logic       o_winner
);

    logic r_prio;
    logic w_winner;

    // Combinational pick: a lone requester always wins, a tie goes to r_prio
    always_comb begin
        w_winner = PORT_CPU;
        if (i_req == 2'b11) begin
            w_winner = r_prio;
        end else if (i_req[1]) begin
            w_winner = PORT_LOADER;
        end
    end

    assign o_valid  = |i_req;
    assign o_winner = w_winner;

    // Priority pointer: after a grant the other port is favoured next time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PORT_CPU;
        end else if (i_accept && o_valid) begin
            r_prio <= ~w_winner;
        end
    end

endmodule : rr_arbiter2

// File: rtl/ram_arbiter.sv
// Two-port shared-RAM arbiter. Port 0 (CPU) and port 1 (loader) request
// single accesses; a round-robin picker selects one in IDLE, the access is
// issued to the RAM for one cycle (ISSUE) and, for reads, the RAM data is
// returned on the following cycle (RWAIT). All outputs except rdata are
// registered so each strobe lines up exactly with its FSM state.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    logic [STATE_W-1:0] r_state;
    logic               r_port;
    logic               r_is_wr;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_we;
    logic [DATA_W-1:0]  r_ram_wdata;
    logic               r_busy;

    logic               w_idle;
    logic               w_valid;
    logic               w_winner;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    assign w_idle = (r_state == ST_IDLE);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({req1, req0}),
        .i_accept (w_idle),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    // Request mux: route the winning port's access attributes
    always_comb begin
        w_sel_we    = we0;
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        if (w_winner == PORT_LOADER) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end
    end

    // FSM and output registers; strobes default low and are set only for
    // the single cycle of the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_port      <= PORT_CPU;
            r_is_wr     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_ram_we  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state     <= ST_ISSUE;
                        r_port      <= w_winner;
                        r_is_wr     <= w_sel_we;
                        r_ram_addr  <= w_sel_addr;
                        r_ram_wdata <= w_sel_wdata;
                        r_ram_we    <= w_sel_we;
                        r_gnt0      <= (w_winner == PORT_CPU);
                        r_gnt1      <= (w_winner == PORT_LOADER);
                        r_busy      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (r_is_wr) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= ST_RWAIT;
                        r_rvalid0 <= (r_port == PORT_CPU);
                        r_rvalid1 <= (r_port == PORT_LOADER);
                    end
                end
                ST_RWAIT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata     = ram_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign busy      = r_busy;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy;

    logic [15:0] mem [256];
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [15:0] tb_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // RAM model: one-cycle read latency, bench back-door write for preloads
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Invariants on every cycle: one-hot strobes, write enable only with a grant
    always @(negedge clk) begin
        check("inv_gnt_onehot", 32'($onehot0({gnt1, gnt0})), 32'd1);
        check("inv_rvalid_onehot", 32'($onehot0({rvalid1, rvalid0})), 32'd1);
        check("inv_we_in_issue", 32'(ram_we & ~(gnt0 | gnt1)), 32'd0);
    end

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // One access from an idle arbiter, checked from request to completion
    task automatic access(input int port, input logic wr, input logic [7:0] a,
                          input logic [15:0] wd, input logic [15:0] exp);
        logic got_g;
        int   lat;
        got_g = 1'b0;
        lat   = 0;
        if (port == 0) begin req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd; end
        else           begin req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = wd; end
        for (int c = 1; c <= 10 && !got_g; c++) begin
            @(negedge clk);
            if ((port == 0 && gnt0) || (port == 1 && gnt1)) begin
                got_g = 1'b1;
                lat   = c;
            end
        end
        check("acc_gnt", 32'(got_g), 32'd1);
        if (got_g) begin
            check("acc_lat", lat, 1);
            check("acc_ram_we", 32'(ram_we), 32'(wr));
            check("acc_ram_addr", 32'(ram_addr), 32'(a));
            if (wr) check("acc_ram_wdata", 32'(ram_wdata), 32'(wd));
        end
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        if (got_g && !wr) begin
            @(negedge clk);
            check("acc_rvalid", 32'(port == 0 ? rvalid0 : rvalid1), 32'd1);
            check("acc_rvalid_other", 32'(port == 0 ? rvalid1 : rvalid0), 32'd0);
            check("acc_rdata", 32'(rdata), 32'(exp));
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, nrv, last, exp_port;
        logic saw;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tb_we = 0; tb_addr = '0; tb_wdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'({gnt1, gnt0}), 0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);

        // Request held during reset is ignored, then served right after release
        req0 = 1; we0 = 1; addr0 = 8'h00; wdata0 = 16'h5A5A;
        @(negedge clk);
        check("rst_ignore_gnt", 32'(gnt0), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gnt0", 32'(gnt0), 1);
        check("post_rst_we", 32'(ram_we), 1);
        check("post_rst_addr", 32'(ram_addr), 32'h00);
        check("post_rst_wdata", 32'(ram_wdata), 32'h5A5A);
        req0 = 0;
        @(negedge clk);

        // Single read with cycle-exact timing (pointer now favours port 1)
        poke(8'h10, 16'hBEEF);
        poke(8'h30, 16'h0300);
        poke(8'h31, 16'h1311);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        check("rd_c0_busy", 32'(busy), 0);
        @(negedge clk);
        check("rd_c1_gnt0", 32'(gnt0), 1);
        check("rd_c1_gnt1", 32'(gnt1), 0);
        check("rd_c1_busy", 32'(busy), 1);
        check("rd_c1_addr", 32'(ram_addr), 32'h10);
        check("rd_c1_we", 32'(ram_we), 0);
        check("rd_c1_rvalid", 32'(rvalid0), 0);
        req0 = 0;
        @(negedge clk);
        check("rd_c2_rvalid0", 32'(rvalid0), 1);
        check("rd_c2_rdata", 32'(rdata), 32'hBEEF);
        check("rd_c2_gnt0", 32'(gnt0), 0);
        check("rd_c2_busy", 32'(busy), 1);
        @(negedge clk);
        check("rd_c3_busy", 32'(busy), 0);
        check("rd_c3_rvalid0", 32'(rvalid0), 0);

        // Write from port 1 then read back from port 0
        access(1, 1'b1, 8'h7F, 16'h1234, 16'h0000);
        access(0, 1'b0, 8'h7F, 16'h0000, 16'h1234);

        // A request dropped while the arbiter is busy is never served
        req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk);
        check("drop_gnt0", 32'(gnt0), 1);
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 16'hDEAD;
        @(negedge clk);
        req1 = 0;
        saw = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (gnt1) saw = 1'b1;
        end
        check("drop_no_gnt1", 32'(saw), 0);

        // Contention: both ports read continuously, grants must alternate
        rst = 1; @(negedge clk); rst = 0;
        req0 = 1; we0 = 0; addr0 = 8'h30;
        req1 = 1; we1 = 0; addr1 = 8'h31;
        ng = 0; nrv = 0; last = 0; exp_port = 0;
        for (int c = 1; c <= 40 && nrv < 8; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                check("cont_port", 32'(gnt1), 32'(exp_port));
                check("cont_gap", c - last, (ng == 0) ? 1 : 3);
                last = c;
                ng++;
                exp_port = 1 - exp_port;
                if (ng == 8) begin req0 = 0; req1 = 0; end
            end
            if (rvalid0) begin check("cont_rdata0", 32'(rdata), 32'h0300); nrv++; end
            if (rvalid1) begin check("cont_rdata1", 32'(rdata), 32'h1311); nrv++; end
        end
        check("cont_grants", ng, 8);
        check("cont_rvalids", nrv, 8);
        @(negedge clk);

        // Reset in RWAIT: abort, then a tie goes to port 0 again
        req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk);
        check("rstrw_gnt0", 32'(gnt0), 1);
        req0 = 0;
        @(negedge clk);
        check("rstrw_in_rwait", 32'(busy), 1);
        rst = 1;
        @(negedge clk);
        check("rstrw_busy", 32'(busy), 0);
        check("rstrw_rvalid", 32'({rvalid1, rvalid0}), 0);
        rst = 0;
        req0 = 1; we0 = 0; addr0 = 8'h30;
        req1 = 1; we1 = 0; addr1 = 8'h31;
        @(negedge clk);
        check("rstrw_tie_gnt0", 32'(gnt0), 1);
        check("rstrw_tie_gnt1", 32'(gnt1), 0);
        req0 = 0; req1 = 0;
        @(negedge clk);
        check("rstrw_tie_rdata", 32'(rdata), 32'h0300);
        check("rstrw_tie_rvalid0", 32'(rvalid0), 1);
        @(negedge clk);

        // Reset in ISSUE of a read: no rvalid afterwards
        req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk);
        check("rstis_gnt0", 32'(gnt0), 1);
        req0 = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        check("rstis_rvalid", 32'({rvalid1, rvalid0}), 0);
        check("rstis_busy", 32'(busy), 0);
        @(negedge clk);
        check("rstis_rvalid_late", 32'({rvalid1, rvalid0}), 0);

        // Reset in ISSUE of a write: write strobe and RAM bus cleared
        req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 16'h4444;
        @(negedge clk);
        check("rstwr_gnt1", 32'(gnt1), 1);
        check("rstwr_we", 32'(ram_we), 1);
        req1 = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        check("rstwr_we_off", 32'(ram_we), 0);
        check("rstwr_addr", 32'(ram_addr), 0);
        check("rstwr_wdata", 32'(ram_wdata), 0);
        @(negedge clk);

        // Address boundary: top address does not alias address zero
        access(0, 1'b1, 8'hFF, 16'hA5A5, 16'h0000);
        access(0, 1'b0, 8'hFF, 16'h0000, 16'hA5A5);
        access(0, 1'b0, 8'h00, 16'h0000, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_arbiter
